// File: rtl/piso_pkg.sv
// Shared types and constants for the parallel-in / serial-out shift register.
// The PARITY state is present only when PISO_PARITY_EN is defined.
package piso_pkg;

`ifdef PISO_PARITY_EN
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_PARITY = 2'd2
    } piso_state_e;
`else
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1
    } piso_state_e;
`endif

    localparam logic DIR_MSB_FIRST = 1'b0;
    localparam logic DIR_LSB_FIRST = 1'b1;

endpackage

// File: rtl/piso_shift_reg.sv
// Parallel-in / serial-out shift register with valid/ready load and stallable serial output.
// Build option: PISO_PARITY_EN appends an even-parity bit to each frame.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// ST_IDLE   | waiting for a word; load_ready=1, dout=0
// ST_SHIFT  | data bits on dout, advanced by shift_en
// ST_PARITY | even parity of the loaded word on dout, last=1 (PISO_PARITY_EN)
module piso_shift_reg
    import piso_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_data,
    input  logic             dir,
    input  logic             shift_en,
    output logic             dout,
    output logic             dout_valid,
    output logic             last,
    output logic             busy
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    piso_state_e      state_q, state_d;
    logic [WIDTH-1:0] sreg_q, sreg_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             dir_q, dir_d;
`ifdef PISO_PARITY_EN
    logic             parity_q, parity_d;
`endif

    logic dout_q, dout_d;
    logic dout_valid_q, dout_valid_d;
    logic last_q, last_d;
    logic busy_q, busy_d;
    logic load_ready_q, load_ready_d;

    always_comb begin
        state_d  = state_q;
        sreg_d   = sreg_q;
        cnt_d    = cnt_q;
        dir_d    = dir_q;
`ifdef PISO_PARITY_EN
        parity_d = parity_q;
`endif
        case (state_q)
            ST_IDLE: begin
                // load_ready is high throughout IDLE, so load_valid alone qualifies the load
                if (load_valid) begin
                    sreg_d   = load_data;
                    dir_d    = dir;
                    cnt_d    = '0;
                    state_d  = ST_SHIFT;
`ifdef PISO_PARITY_EN
                    parity_d = ^load_data;
`endif
                end
            end
            ST_SHIFT: begin
                if (shift_en) begin
                    if (dir_q == DIR_LSB_FIRST) begin
                        sreg_d = sreg_q >> 1;
                    end else begin
                        sreg_d = sreg_q << 1;
                    end
                    if (cnt_q == CNT_LAST) begin
                        cnt_d = '0;
`ifdef PISO_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_IDLE;
`endif
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
`ifdef PISO_PARITY_EN
            ST_PARITY: begin
                if (shift_en) begin
                    state_d = ST_IDLE;
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs are registered, so they are derived from the next-state values.
    always_comb begin
        dout_d       = 1'b0;
        dout_valid_d = 1'b0;
        last_d       = 1'b0;
        busy_d       = 1'b0;
        load_ready_d = 1'b0;
        case (state_d)
            ST_IDLE: begin
                load_ready_d = 1'b1;
            end
            ST_SHIFT: begin
                dout_d       = (dir_d == DIR_LSB_FIRST) ? sreg_d[0] : sreg_d[WIDTH-1];
                dout_valid_d = 1'b1;
                busy_d       = 1'b1;
`ifndef PISO_PARITY_EN
                last_d       = (cnt_d == CNT_LAST);
`endif
            end
`ifdef PISO_PARITY_EN
            ST_PARITY: begin
                dout_d       = parity_d;
                dout_valid_d = 1'b1;
                busy_d       = 1'b1;
                last_d       = 1'b1;
            end
`endif
            default: begin
                load_ready_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            sreg_q       <= '0;
            cnt_q        <= '0;
            dir_q        <= DIR_MSB_FIRST;
`ifdef PISO_PARITY_EN
            parity_q     <= 1'b0;
`endif
            dout_q       <= 1'b0;
            dout_valid_q <= 1'b0;
            last_q       <= 1'b0;
            busy_q       <= 1'b0;
            load_ready_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            sreg_q       <= sreg_d;
            cnt_q        <= cnt_d;
            dir_q        <= dir_d;
`ifdef PISO_PARITY_EN
            parity_q     <= parity_d;
`endif
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            last_q       <= last_d;
            busy_q       <= busy_d;
            load_ready_q <= load_ready_d;
        end
    end

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign last       = last_q;
    assign busy       = busy_q;
    assign load_ready = load_ready_q;

endmodule

// File: tb/tb_piso_shift_reg.sv
// Directed bench for piso_shift_reg (WIDTH=8); parity-bit checks follow PISO_PARITY_EN.
module tb_piso_shift_reg;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       load_valid;
    logic       load_ready;
    logic [7:0] load_data;
    logic       dir;
    logic       shift_en;
    logic       dout;
    logic       dout_valid;
    logic       last;
    logic       busy;

    int n_vec = 0;
    int n_err = 0;

`ifdef PISO_PARITY_EN
    localparam logic HAS_PAR = 1'b1;
`else
    localparam logic HAS_PAR = 1'b0;
`endif

    piso_shift_reg #(.WIDTH(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_data  (load_data),
        .dir        (dir),
        .shift_en   (shift_en),
        .dout       (dout),
        .dout_valid (dout_valid),
        .last       (last),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, " idle load_ready"}, 32'(load_ready), 32'd1);
        chk({tag, " idle dout_valid"}, 32'(dout_valid), 32'd0);
        chk({tag, " idle busy"}, 32'(busy), 32'd0);
        chk({tag, " idle dout"}, 32'(dout), 32'd0);
        chk({tag, " idle last"}, 32'(last), 32'd0);
    endtask

    // exp_bits[7] is the first serial bit expected on dout.
    task automatic frame(input string tag, input logic [7:0] word, input logic d,
                         input logic [7:0] exp_bits, input logic stall,
                         input logic exp_par, input logic keep_valid);
        load_valid = 1'b1;
        load_data  = word;
        dir        = d;
        shift_en   = 1'b1;
        step();
        if (!keep_valid) load_valid = 1'b0;
        load_data = ~word;
        dir       = ~d;
        for (int i = 0; i < 8; i++) begin
            if (stall) begin
                shift_en = 1'b0;
                chk($sformatf("%s bit%0d pre-stall", tag, i), 32'(dout), 32'(exp_bits[7-i]));
                step();
                chk($sformatf("%s bit%0d held", tag, i), 32'(dout), 32'(exp_bits[7-i]));
                shift_en = 1'b1;
            end
            chk($sformatf("%s bit%0d dout", tag, i), 32'(dout), 32'(exp_bits[7-i]));
            chk($sformatf("%s bit%0d valid", tag, i), 32'(dout_valid), 32'd1);
            chk($sformatf("%s bit%0d busy", tag, i), 32'(busy), 32'd1);
            chk($sformatf("%s bit%0d load_ready", tag, i), 32'(load_ready), 32'd0);
            chk($sformatf("%s bit%0d last", tag, i), 32'(last), 32'((i == 7) && !HAS_PAR));
            step();
        end
        if (HAS_PAR) begin
            chk({tag, " parity dout"}, 32'(dout), 32'(exp_par));
            chk({tag, " parity valid"}, 32'(dout_valid), 32'd1);
            chk({tag, " parity last"}, 32'(last), 32'd1);
            step();
        end
        chk_idle({tag, " end"});
    endtask

    initial begin
        rst_n      = 1'b1;
        load_valid = 1'b0;
        load_data  = 8'h00;
        dir        = 1'b0;
        shift_en   = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk_idle("reset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        frame("A5 msb", 8'hA5, 1'b0, 8'b1010_0101, 1'b0, 1'b0, 1'b0);
        frame("A5 lsb", 8'hA5, 1'b1, 8'b1010_0101, 1'b0, 1'b0, 1'b0);
        frame("01 lsb", 8'h01, 1'b1, 8'b1000_0000, 1'b0, 1'b1, 1'b0);

        // shift_en in IDLE must not start anything
        shift_en = 1'b1;
        step();
        step();
        chk_idle("idle shift_en");

        frame("F0 stall", 8'hF0, 1'b0, 8'b1111_0000, 1'b1, 1'b0, 1'b0);

        // abort C3 after three bits have been taken
        load_valid = 1'b1;
        load_data  = 8'hC3;
        dir        = 1'b0;
        shift_en   = 1'b1;
        step();
        load_valid = 1'b0;
        chk("C3 bit0", 32'(dout), 32'd1);
        step();
        chk("C3 bit1", 32'(dout), 32'd1);
        step();
        chk("C3 bit2", 32'(dout), 32'd0);
        step();
        chk("C3 bit3 busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk_idle("async reset");
        step();
        chk_idle("reset held");
        @(negedge clk);
        rst_n = 1'b1;
        frame("3C after reset", 8'h3C, 1'b0, 8'b0011_1100, 1'b0, 1'b0, 1'b0);

        // load_valid held high: FF then 00, with an IDLE bubble between
        frame("FF b2b", 8'hFF, 1'b0, 8'b1111_1111, 1'b0, 1'b0, 1'b1);
        frame("00 b2b", 8'h00, 1'b0, 8'b0000_0000, 1'b0, 1'b0, 1'b0);

        frame("07 msb", 8'h07, 1'b0, 8'b0000_0111, 1'b0, 1'b1, 1'b0);
        frame("03 msb", 8'h03, 1'b0, 8'b0000_0011, 1'b0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/piso_shift_reg.md
PISO_SHIFT_REG -- requirements
Module: piso_shift_reg

Interface
REQ-001 Parameter WIDTH, default 8, data word width in bits (legal range 2..32).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 load_valid  input  1  parallel word offered on load_data.
REQ-005 load_ready  output  1  block can accept a new word.
REQ-006 load_data  input  WIDTH  parallel word to serialize.
REQ-007 dir  input  1  bit order, sampled at load: 0 = MSB first, 1 = LSB first.
REQ-008 shift_en  input  1  consumer strobe; current serial bit is taken when high.
REQ-009 dout  output  1  current serial bit.
REQ-010 dout_valid  output  1  dout holds a valid bit.
REQ-011 last  output  1  dout holds the final bit of the frame.
REQ-012 busy  output  1  a frame is in progress.

Function
REQ-013 FSM states: IDLE, SHIFT, and PARITY (PARITY exists only when the macro is defined); reset state is IDLE.
REQ-014 IDLE: load_ready=1, dout_valid=0, busy=0; a load occurs on a rising edge when load_valid&&load_ready.
REQ-015 Load: capture load_data into the shift register, latch dir, clear the bit counter, and enter SHIFT on the next cycle.
REQ-016 SHIFT: load_ready=0, busy=1, dout_valid=1; dout = reg[WIDTH-1] when latched dir=0, or reg[0] when latched dir=1.
REQ-017 SHIFT with shift_en=1: shift the register one place toward the output end, fill with 0, and increment the counter.
REQ-018 SHIFT with shift_en=0: hold all state; dout stays stable (stall, no bit lost).
REQ-019 last=1 in SHIFT exactly when counter==WIDTH-1, and only when the PARITY state is compiled out.
REQ-020 Counter==WIDTH-1 with shift_en=1: go to IDLE, or to PARITY when it is compiled in.
REQ-021 Latency: first bit is valid on dout 1 cycle after the load edge; a WIDTH-bit frame with shift_en held high completes in WIDTH cycles.
REQ-022 Back-to-back frames: there is one IDLE cycle (load_ready=1) between frames; load_valid is ignored outside IDLE.
REQ-023 dir and load_data changes outside the load edge do not affect a frame in progress.
REQ-024 shift_en in IDLE is ignored; dout=0 in IDLE.
REQ-025 Counter width is $clog2(WIDTH); the counter never exceeds WIDTH-1.

Reset
REQ-026 rst_n low forces, asynchronously: state=IDLE, shift register=0, counter=0, latched dir=0, dout=0, dout_valid=0, last=0, busy=0, load_ready=1.
REQ-027 Reset asserted mid-frame aborts the frame; no residual bits are emitted after release.
REQ-028 The first load is accepted on the first rising edge after rst_n deasserts.

Configuration
REQ-029 Macro PISO_PARITY_EN compiled in: after the last data bit, the PARITY state drives dout = even parity (XOR) of the loaded word, with dout_valid=1 and last=1; shift_en=1 in PARITY returns to IDLE, and the frame is WIDTH+1 bits.
REQ-030 Macro compiled out: no PARITY state and no parity logic; the frame is WIDTH bits.

Structure
REQ-031 Shared package piso_pkg holds the state enum typedef and the constants DIR_MSB_FIRST=0 and DIR_LSB_FIRST=1.
REQ-032 No sub-module: the counter, shift register and FSM are inline in piso_shift_reg.

Verification
REQ-033 WIDTH=8, load 8'hA5 with dir=0, shift_en held high -> dout sequence 1,0,1,0,0,1,0,1; last on the 8th bit; load_ready=1 on the next cycle.
REQ-034 Load 8'hA5 with dir=1 -> dout 1,0,1,0,0,1,0,1 (LSB first); then load 8'h01 with dir=1 -> 1,0,0,0,0,0,0,0.
REQ-035 Load 8'hF0 with dir=0, shift_en toggling 1/0 -> each bit held through the stall; 8 bits are emitted over 16 cycles in the order 1,1,1,1,0,0,0,0.
REQ-036 Assert rst_n low after bit 3 of 8'hC3 -> all outputs go to their reset values immediately; a new load of 8'h3C is serialized correctly.
REQ-037 load_valid held high with 8'hFF then 8'h00 presented back-to-back -> the second word is accepted only after the IDLE bubble; the word changing mid-frame does not corrupt the output.
REQ-038 PISO_PARITY_EN defined, load 8'h07 -> 8 data bits then parity bit 1 with last=1; load 8'h03 -> parity bit 0.
